// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with synchronous clear/load,
// load validation, and either wrap-around or hold-at-limit behaviour.
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  load_error
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_load_error;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_all9;
  logic         w_all0;
  logic         w_load_ok;
  logic         w_at_limit;
  logic         w_hold;

  // w_all9 / w_all0 double as the ripple conditions: while walking up the
  // digits they hold "every lower digit is 9 / 0" before being updated.
  always_comb begin
    logic [3:0] v_d;
    w_inc     = r_count;
    w_dec     = r_count;
    w_all9    = 1'b1;
    w_all0    = 1'b1;
    w_load_ok = 1'b1;
    v_d       = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      v_d = r_count[4*k +: 4];
      if (w_all9) w_inc[4*k +: 4] = (v_d == 4'd9) ? 4'd0 : v_d + 4'd1;
      if (w_all0) w_dec[4*k +: 4] = (v_d == 4'd0) ? 4'd9 : v_d - 4'd1;
      w_all9 = w_all9 & (v_d == 4'd9);
      w_all0 = w_all0 & (v_d == 4'd0);
      if (load_value[4*k +: 4] > 4'd9) w_load_ok = 1'b0;
    end
  end

  assign w_at_limit = up_down ? w_all9 : w_all0;
  assign w_hold     = w_at_limit && (SATURATE != 0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_carry      <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_carry      <= 1'b0;
      r_load_error <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load) begin
        if (w_load_ok) r_count      <= load_value;
        else           r_load_error <= 1'b1;
      end else if (enable) begin
        // Wrap and blocked-saturation both report through carry_out.
        r_carry <= w_at_limit;
        if (!w_hold) r_count <= up_down ? w_inc : w_dec;
      end
    end
  end

  assign count      = r_count;
  assign carry_out  = r_carry;
  assign load_error = r_load_error;
  assign at_max     = w_all9;
  assign at_zero    = w_all0;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a wrapping and a saturating instance share the
// stimulus; an integer-valued model predicts both every cycle.
module tb_bcd_counter_n;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 999;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         up_down;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;

  logic [W-1:0] count, count_s;
  logic         carry_out, at_max, at_zero, load_error;
  logic         carry_s, max_s, zero_s, lerr_s;

  int n_cmp = 0;
  int n_bad = 0;

  // index 0 = wrapping instance, 1 = saturating instance
  int   m_val[2];
  logic m_carry[2];
  logic m_lerr[2];

  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count(count),
    .carry_out(carry_out), .at_max(at_max), .at_zero(at_zero),
    .load_error(load_error)
  );

  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count(count_s),
    .carry_out(carry_s), .at_max(max_s), .at_zero(zero_s),
    .load_error(lerr_s)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]);
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_val[i]   = 0;
        m_carry[i] = 1'b0;
        m_lerr[i]  = 1'b0;
      end else begin
        m_carry[i] = 1'b0;
        m_lerr[i]  = 1'b0;
        if (clear) begin
          m_val[i] = 0;
        end else if (load) begin
          if (bcd_ok(load_value)) m_val[i] = from_bcd(load_value);
          else                    m_lerr[i] = 1'b1;
        end else if (enable) begin
          if (up_down) begin
            if (m_val[i] == MAXV) begin
              m_carry[i] = 1'b1;
              if (i == 0) m_val[i] = 0;
            end else m_val[i] = m_val[i] + 1;
          end else begin
            if (m_val[i] == 0) begin
              m_carry[i] = 1'b1;
              if (i == 0) m_val[i] = MAXV;
            end else m_val[i] = m_val[i] - 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clock) begin
    chk("count",      32'(count),      32'(to_bcd(m_val[0])));
    chk("carry_out",  32'(carry_out),  32'(m_carry[0]));
    chk("load_error", 32'(load_error), 32'(m_lerr[0]));
    chk("at_max",     32'(at_max),     32'(m_val[0] == MAXV));
    chk("at_zero",    32'(at_zero),    32'(m_val[0] == 0));
    chk("sat_count",  32'(count_s),    32'(to_bcd(m_val[1])));
    chk("sat_carry",  32'(carry_s),    32'(m_carry[1]));
    chk("sat_lerr",   32'(lerr_s),     32'(m_lerr[1]));
    chk("sat_max",    32'(max_s),      32'(m_val[1] == MAXV));
    chk("sat_zero",   32'(zero_s),     32'(m_val[1] == 0));
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n_carry;
    int n_max;
    int r;
    reset = 1'b1; enable = 1'b0; up_down = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = '0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_at_zero", 32'(at_zero), 32'h1);

    // full up-count cycle 000..999 -> 000
    enable = 1'b1; up_down = 1'b1;
    n_carry = 0; n_max = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (carry_out) begin
        n_carry++;
        chk("carry_at_000", 32'(count), 32'h0);
      end
      if (at_max) begin
        n_max++;
        chk("at_max_at_999", 32'(count), 32'h999);
      end
      if (i == 498) chk("mid_count", 32'(count), 32'h499);
    end
    chk("wrap_end", 32'(count), 32'h0);
    chk("wrap_carry_pulses", 32'(n_carry), 32'd1);
    chk("at_max_cycles", 32'(n_max), 32'd1);

    // borrow across two digits
    enable = 1'b0; load = 1'b1; load_value = 12'h100;
    tick();
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    tick();
    enable = 1'b0;
    chk("borrow_count", 32'(count), 32'h099);
    chk("borrow_carry", 32'(carry_out), 32'h0);
    chk("borrow_at_zero", 32'(at_zero), 32'h0);

    // saturating decrement at zero
    clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold_zero", 32'(count_s), 32'h0);
      chk("sat_hold_carry", 32'(carry_s), 32'h1);
    end
    enable = 1'b0;
    chk("wrap_down_count", 32'(count), 32'h997);

    // rejected load
    load = 1'b1; load_value = 12'h1A5;
    tick();
    load = 1'b0;
    chk("bad_load_count", 32'(count), 32'h997);
    chk("bad_load_error", 32'(load_error), 32'h1);
    tick();
    chk("bad_load_pulse_end", 32'(load_error), 32'h0);

    // priority clear > load > enable
    clear = 1'b1; load = 1'b1; load_value = 12'h555; enable = 1'b1; up_down = 1'b1;
    tick();
    chk("prio_clear", 32'(count), 32'h0);
    clear = 1'b0;
    tick();
    chk("prio_load", 32'(count), 32'h555);
    load = 1'b0; enable = 1'b0;

    // asynchronous reset between edges
    load = 1'b1; load_value = 12'h473;
    tick();
    load = 1'b0;
    chk("pre_reset_count", 32'(count), 32'h473);
    enable = 1'b1; up_down = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(count), 32'h0);
    chk("async_reset_carry", 32'(carry_out), 32'h0);
    chk("async_reset_lerr", 32'(load_error), 32'h0);
    @(negedge clock);
    #1 reset = 1'b0;
    tick();
    chk("resume_count", 32'(count), 32'h001);
    enable = 1'b0;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r       = $urandom_range(0, 99);
      clear   = (r < 4);
      load    = ($urandom_range(0, 99) < 15);
      enable  = ($urandom_range(0, 99) < 70);
      up_down = $urandom_range(0, 1) != 0;
      r = $urandom_range(0, 9);
      if (r < 6)       load_value = to_bcd($urandom_range(0, MAXV));
      else if (r == 6) load_value = 12'h999;
      else if (r == 7) load_value = 12'h000;
      else             load_value = W'($urandom_range(0, 4095));
      tick();
    end
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD digits, legal range 1..8.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  count one step this cycle.
REQ-006 SHALL have port up_down  input  1  1 = increment, 0 = decrement.
REQ-007 SHALL have port clear  input  1  synchronous return to zero.
REQ-008 SHALL have port load  input  1  synchronous load of load_value.
REQ-009 SHALL have port load_value  input  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
REQ-010 SHALL have port count  output  4*DIGITS  packed BCD count, same packing as load_value.
REQ-011 SHALL have port carry_out  output  1  one-cycle pulse on wrap or saturation hit.
REQ-012 SHALL have port at_max  output  1  count equals all digits 9.
REQ-013 SHALL have port at_zero  output  1  count equals all digits 0.
REQ-014 SHALL have port load_error  output  1  one-cycle pulse on a rejected load.

Function
REQ-015 SHALL resolve same-edge controls with priority clear > load > enable; lower-priority requests in that cycle are discarded.
REQ-016 SHALL set count to zero on the next edge when clear=1.
REQ-017 SHALL copy load_value into count on the next edge when load=1 and every digit of load_value is <= 9.
REQ-018 SHALL leave count unchanged and pulse load_error for exactly one cycle when load=1 and any digit of load_value is > 9.
REQ-019 SHALL add 1 in decimal when enable=1 and up_down=1: digit k increments only if digits 0..k-1 are all 9; a digit at 9 rolls to 0.
REQ-020 SHALL subtract 1 in decimal when enable=1 and up_down=0: digit k decrements only if digits 0..k-1 are all 0; a digit at 0 rolls to 9.
REQ-021 SHALL, with SATURATE=0, wrap all-9 +1 to all-0 and all-0 -1 to all-9.
REQ-022 SHALL, with SATURATE=1, hold count on an increment at all-9 or a decrement at all-0.
REQ-023 SHALL register carry_out high for exactly the one cycle following an edge at which REQ-021 wrapped or REQ-022 blocked a step.
REQ-024 SHALL assert carry_out for every such edge, so continuous enable at a saturated limit holds carry_out high.
REQ-025 SHALL leave count unchanged, with carry_out low, when enable=0, load=0 and clear=0.
REQ-026 SHALL decode at_max and at_zero combinationally from the count register, so they are valid in the same cycle as count.
REQ-027 SHALL never hold a digit value above 9 in count.
REQ-028 SHALL have one clock latency from control inputs to count, carry_out and load_error.
REQ-029 SHALL use no internal state beyond the count register and the carry_out and load_error flops.

Reset
REQ-030 SHALL, on reset=1, asynchronously drive count=0, carry_out=0 and load_error=0 regardless of clock.
REQ-031 SHALL resume on the first rising clock edge after reset deasserts, evaluating controls normally.
REQ-032 SHALL abort a pending load or count when reset asserts mid-cycle, with no partial digit update.

Verification (DIGITS=3 unless noted)
REQ-033 SHALL be verified by: reset, then enable=1 and up_down=1 for 1000 cycles -> count steps 000..999, then 000; carry_out pulses once, on the cycle count reads 000; at_max high only while count is 999.
REQ-034 SHALL be verified by: load 0x100, then one decrement -> count=0x099; carry_out=0; at_zero=0.
REQ-035 SHALL be verified by: SATURATE=1, count=000, enable=1, up_down=0 for 3 cycles -> count stays 000; carry_out high for all 3 cycles.
REQ-036 SHALL be verified by: load_value=0x1A5 with load=1 -> count unchanged; load_error high for exactly one cycle.
REQ-037 SHALL be verified by: clear=1, load=1 (0x555) and enable=1 on the same edge -> count=000. Then load=1 (0x555) with enable=1 -> count=0x555, not 0x556.
REQ-038 SHALL be verified by: assert reset between edges while count=0x473 -> count=000 immediately, before the next edge; carry_out=0; load_error=0.
